lut_frac_chain: RTL and testbench

LUT_FRAC_CHAIN -- requirements
Module: lut_frac_chain

---
 rtl/lut_frac_pkg.sv | 19 +
 rtl/lut_frac_cell.sv | 15 +
 rtl/lut_frac_chain.sv | 128 ++++++++++++
 tb/tb_lut_frac_chain.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lut_frac_pkg.sv
// Shared types and size helpers for the fracturable chained LUT.
// Readback option: LUT_FRAC_READBACK_EN.
package lut_frac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic int mem_size_f(input int k);
        return 1 << k;
    endfunction

    function automatic int frame_f(input int k, input int l);
        return l * mem_size_f(k) + l - 1;
    endfunction

endpackage

// File: rtl/lut_frac_cell.sv
// Single K-input truth-table read mux.
// Readback option (LUT_FRAC_READBACK_EN) does not affect this cell.
module lut_frac_cell
    import lut_frac_pkg::*;
#(
    parameter int INPUTS = 4
) (
    input  logic [mem_size_f(INPUTS)-1:0] tbl,
    input  logic [INPUTS-1:0]             sel,
    output logic                          o
);

    assign o = tbl[sel];

endmodule

// File: rtl/lut_frac_chain.sv
// Fracturable LUT with chained sub-LUTs and double-buffered serial config.
// Define LUT_FRAC_READBACK_EN to preload the shadow for scan-out readback.
module lut_frac_chain
    import lut_frac_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int LUTS   = 2
) (
    input  logic                                      cclk,
    input  logic                                      rst,
    input  logic [INPUTS*LUTS-1:0]                    addr,
    output logic [LUTS-1:0]                           out,
    input  logic                                      cfg_start,
    input  logic                                      cfg_in,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    output logic                                      cfg_out,
    output logic                                      cfg_done,
    input  logic                                      data_in,
    input  logic                                      write_en,
    input  logic [$clog2(LUTS*(2**INPUTS))-1:0]       write_addr,
    output logic                                      write_err
);

    localparam int MEM_SIZE = mem_size_f(INPUTS);
    localparam int FRAME    = frame_f(INPUTS, LUTS);
    localparam int TBL_BITS = LUTS * MEM_SIZE;
    localparam int AW       = $clog2(TBL_BITS);
    localparam int CW       = $clog2(FRAME + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME-1:0]      shadow_q, shadow_d;
    logic [TBL_BITS-1:0]   tbl_q, tbl_d;
    logic [LUTS-2:0]       chain_q, chain_d;
    logic                  write_err_q, write_err_d;

    logic                  accept;
    logic                  start;
    logic                  wr_in_range;
    logic                  wr_ok;

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            tbl_q       <= '0;
            chain_q     <= '0;
            write_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            tbl_q       <= tbl_d;
            chain_q     <= chain_d;
            write_err_q <= write_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cfg_start) state_d = ST_SHIFT;
            ST_SHIFT:  if (accept && cnt_q == CW'(FRAME - 1)) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == ST_SHIFT);
        cfg_done  = (state_q == ST_COMMIT);
`ifdef LUT_FRAC_READBACK_EN
        cfg_out   = shadow_q[FRAME-1];
`else
        cfg_out   = 1'b0;
`endif
        write_err = write_err_q;
    end

    assign accept      = cfg_valid && cfg_ready;
    assign start       = (state_q == ST_IDLE) && cfg_start;
    assign wr_in_range = {1'b0, write_addr} < (AW + 1)'(TBL_BITS);
    assign wr_ok       = write_en && wr_in_range && (state_q == ST_IDLE);

    always_comb begin
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        tbl_d       = tbl_q;
        chain_d     = chain_q;
        write_err_d = write_en && !wr_ok;
        if (start) begin
            cnt_d = '0;
`ifdef LUT_FRAC_READBACK_EN
            shadow_d = {chain_q, tbl_q};
`endif
        end else if (accept) begin
            cnt_d    = cnt_q + 1'b1;
            shadow_d = {shadow_q[FRAME-2:0], cfg_in};
        end
        // Active state only moves on commit or an IDLE single-bit write.
        if (state_q == ST_COMMIT) begin
            {chain_d, tbl_d} = shadow_q;
        end else if (wr_ok) begin
            tbl_d[write_addr] = data_in;
        end
    end

    for (genvar j = 0; j < LUTS; j++) begin : g_lut
        logic msb;
        logic o;
        if (j == LUTS - 1) begin : g_top
            assign msb = addr[j*INPUTS+INPUTS-1];
        end else begin : g_chn
            assign msb = chain_q[j] ? g_lut[j+1].o : addr[j*INPUTS+INPUTS-1];
        end
        lut_frac_cell #(
            .INPUTS (INPUTS)
        ) u_cell (
            .tbl (tbl_q[j*MEM_SIZE +: MEM_SIZE]),
            .sel ({msb, addr[j*INPUTS +: INPUTS-1]}),
            .o   (o)
        );
        assign out[j] = o;
    end

endmodule

// File: tb/tb_lut_frac_chain.sv
// Directed bench for lut_frac_chain, INPUTS=4, LUTS=2 (33-bit frame).
// Readback checks switch on with LUT_FRAC_READBACK_EN.
module tb_lut_frac_chain;

    logic       cclk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic [1:0] out;
    logic       cfg_start, cfg_in, cfg_valid;
    logic       cfg_ready, cfg_out, cfg_done;
    logic       data_in, write_en, write_err;
    logic [4:0] write_addr;

    int n_asrt = 0;
    int n_fail = 0;

`ifdef LUT_FRAC_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    localparam logic [32:0] F38 = {1'b0, 16'hFFFF, 16'h8000};
    localparam logic [32:0] F39 = {1'b1, 16'h0001, 16'hFF00};

    logic [32:0] prev_frame = '0;

    always #5 cclk = ~cclk;

    lut_frac_chain #(.INPUTS(4), .LUTS(2)) dut (
        .cclk       (cclk),
        .rst        (rst),
        .addr       (addr),
        .out        (out),
        .cfg_start  (cfg_start),
        .cfg_in     (cfg_in),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_out    (cfg_out),
        .cfg_done   (cfg_done),
        .data_in    (data_in),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_err  (write_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    // mode 0: all zero, 1: first frame, 2: chained frame
    task automatic sweep(input string tag, input int mode);
        logic [7:0] av;
        logic       hi;
        for (int a = 0; a < 256; a++) begin
            av   = a[7:0];
            addr = av;
            #1;
            hi = (av[7:4] == 4'h0);
            if (mode == 0)      chk(tag, out, 2'b00);
            else if (mode == 1) chk(tag, out, {1'b1, av[3:0] == 4'hF});
            else                chk(tag, out, {hi, hi});
        end
    endtask

    task automatic shift_frame(input logic [32:0] f, input bit gap,
                               input int restart_at);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("ready_in_shift", cfg_ready, 1);
        for (int i = 32; i >= 0; i--) begin
            chk("cfg_out_stream", cfg_out, RB ? prev_frame[i] : 1'b0);
            cfg_in    = f[i];
            cfg_valid = 1'b1;
            cfg_start = (i == restart_at);
            tick();
            cfg_valid = 1'b0;
            cfg_start = 1'b0;
            if (i > 0) begin
                chk("no_early_done", cfg_done, 0);
                if (gap) begin
                    tick();
                    chk("stall_ready", cfg_ready, 1);
                end
            end
        end
        chk("cfg_done", cfg_done, 1);
        chk("ready_in_commit", cfg_ready, 0);
        tick();
        chk("done_one_cycle", cfg_done, 0);
        prev_frame = f;
    endtask

    initial begin
        rst = 1'b1; addr = '0;
        cfg_start = 0; cfg_in = 0; cfg_valid = 0;
        data_in = 0; write_en = 0; write_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", cfg_ready, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_werr", write_err, 0);
        chk("rst_cfg_out", cfg_out, 0);
        sweep("rst_out", 0);

        shift_frame(F38, 1'b0, -1);
        sweep("frame_a", 1);

        shift_frame(F39, 1'b1, -1);
        sweep("frame_chain", 2);

        addr = 8'h13;
        #1;
        chk("pre_write", out, 2'b00);
        write_addr = 5'd3; data_in = 1'b1; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        chk("idle_write_err", write_err, 0);
        chk("idle_write_out", out, 2'b01);
        prev_frame[3] = 1'b1;

        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 32; i > 22; i--) begin
            cfg_in = F38[i]; cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        data_in = 1'b0; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        chk("shift_write_err", write_err, 1);
        chk("shift_write_out", out, 2'b01);
        chk("shift_ready", cfg_ready, 1);
        tick();
        chk("werr_pulse", write_err, 0);
        for (int i = 22; i > 12; i--) begin
            cfg_in = F38[i]; cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        chk("held_out", out, 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_frame = '0;
        chk("mid_rst_ready", cfg_ready, 0);
        chk("mid_rst_done", cfg_done, 0);
        chk("mid_rst_cfg_out", cfg_out, 0);
        sweep("mid_rst_out", 0);

        shift_frame(F38, 1'b0, 20);
        sweep("reload_a", 1);

        shift_frame(F39, 1'b0, -1);
        sweep("reload_chain", 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
